// File: rtl/fsm_io_pkg.sv
// Shared types and default timing constants for the input conditioner.
package fsm_io_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;
    localparam int unsigned AUTO_PERIOD_DEFAULT     = 8;

    typedef enum logic [1:0] {
        BTN_IDLE         = 2'd0,
        BTN_PRESS_WAIT   = 2'd1,
        BTN_HELD         = 2'd2,
        BTN_RELEASE_WAIT = 2'd3
    } btn_state_e;

endpackage

// File: rtl/fsm_input_conditioner_if.sv
// Raw inputs in, conditioned strobes and debug state out.
interface fsm_input_conditioner_if;
    import fsm_io_pkg::*;

    logic [1:0] sw_raw;
    logic       step_btn;
    logic       auto_en;
    logic [1:0] sw_out;
    logic       step_pulse;
    logic [7:0] step_count;
    btn_state_e btn_state;

    modport master (
        output sw_raw, step_btn, auto_en,
        input  sw_out, step_pulse, step_count, btn_state
    );

    modport slave (
        input  sw_raw, step_btn, auto_en,
        output sw_out, step_pulse, step_count, btn_state
    );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs; cleared by the synchronous reset.
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/fsm_input_conditioner.sv
// Debounces switches and a step button, merges manual and periodic step requests
// into a single-cycle strobe, and counts the strobes.
module fsm_input_conditioner
    import fsm_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned AUTO_PERIOD     = AUTO_PERIOD_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    fsm_input_conditioner_if.slave  bus
);

    localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] AUTO_LAST = 8'(AUTO_PERIOD - 1);

    logic [1:0] sw_sync;
    logic       btn_sync;

    sync2 #(.WIDTH(2)) u_sync_sw (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.sw_raw),
        .q_o   (sw_sync)
    );

    sync2 #(.WIDTH(1)) u_sync_btn (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.step_btn),
        .q_o   (btn_sync)
    );

    logic [1:0] sw_cand_q, sw_cand_d;
    logic [1:0] sw_q, sw_d;
    logic [7:0] sw_cnt_q, sw_cnt_d;

    // The candidate always holds last cycle's synced value, so a mismatch is a change.
    always_comb begin
        sw_cand_d = sw_cand_q;
        sw_cnt_d  = sw_cnt_q;
        sw_d      = sw_q;
        if (sw_sync != sw_cand_q) begin
            sw_cand_d = sw_sync;
            sw_cnt_d  = '0;
        end else if (sw_cand_q != sw_q) begin
            if (sw_cnt_q == DEB_LAST) begin
                sw_d     = sw_cand_q;
                sw_cnt_d = '0;
            end else begin
                sw_cnt_d = sw_cnt_q + 8'd1;
            end
        end
    end

    btn_state_e state_q, state_d;
    logic [7:0] btn_cnt_q, btn_cnt_d;
    logic       manual_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= BTN_IDLE;
            btn_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            btn_cnt_q <= btn_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        btn_cnt_d = btn_cnt_q;
        unique case (state_q)
            BTN_IDLE: begin
                if (btn_sync) begin
                    state_d   = BTN_PRESS_WAIT;
                    btn_cnt_d = '0;
                end
            end
            BTN_PRESS_WAIT: begin
                if (!btn_sync)                    state_d   = BTN_IDLE;
                else if (btn_cnt_q == DEB_LAST)   state_d   = BTN_HELD;
                else                              btn_cnt_d = btn_cnt_q + 8'd1;
            end
            BTN_HELD: begin
                if (!btn_sync) begin
                    state_d   = BTN_RELEASE_WAIT;
                    btn_cnt_d = '0;
                end
            end
            BTN_RELEASE_WAIT: begin
                if (btn_sync)                     state_d   = BTN_HELD;
                else if (btn_cnt_q == DEB_LAST)   state_d   = BTN_IDLE;
                else                              btn_cnt_d = btn_cnt_q + 8'd1;
            end
            default: state_d = BTN_IDLE;
        endcase
    end

    always_comb begin
        manual_req = (state_q == BTN_PRESS_WAIT) && btn_sync && (btn_cnt_q == DEB_LAST);
    end

    logic [7:0] auto_cnt_q, auto_cnt_d;
    logic       auto_req;

    always_comb begin
        auto_req   = bus.auto_en && (auto_cnt_q == AUTO_LAST);
        auto_cnt_d = auto_cnt_q + 8'd1;
        if (!bus.auto_en || auto_req) auto_cnt_d = '0;
    end

    logic       pulse_q, pulse_d;
    logic [7:0] count_q, count_d;

    // A request landing right after a pulse is dropped, never deferred.
    always_comb begin
        pulse_d = (manual_req || auto_req) && !pulse_q;
        count_d = pulse_d ? count_q + 8'd1 : count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_cand_q  <= '0;
            sw_cnt_q   <= '0;
            sw_q       <= '0;
            auto_cnt_q <= '0;
            pulse_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            sw_cand_q  <= sw_cand_d;
            sw_cnt_q   <= sw_cnt_d;
            sw_q       <= sw_d;
            auto_cnt_q <= auto_cnt_d;
            pulse_q    <= pulse_d;
            count_q    <= count_d;
        end
    end

    assign bus.sw_out     = sw_q;
    assign bus.step_pulse = pulse_q;
    assign bus.step_count = count_q;
    assign bus.btn_state  = state_q;

endmodule

// File: tb/tb_fsm_input_conditioner.sv
// Scoreboard bench: stimulus queues expected pulses (cycle, count); a monitor pops them.
module tb_fsm_input_conditioner;
    import fsm_io_pkg::*;

    localparam int unsigned DEB = 4;
    localparam int unsigned AP  = 8;

    logic clk = 1'b0;
    logic reset;

    fsm_input_conditioner_if bus ();

    fsm_input_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .AUTO_PERIOD     (AP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_count = 8'd0;
    bit         prev_pulse = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input int at_cycle);
        exp_t e;
        exp_count = exp_count + 8'd1;
        e.cyc = at_cycle;
        e.cnt = exp_count;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.step_pulse === 1'b1) begin
            check("pulse_not_back_to_back", int'(prev_pulse), 0);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pulse: got step_pulse=1 at cycle %0d, expected 0", cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_step_count", int'(bus.step_count), int'(e.cnt));
            end
        end
        prev_pulse = bus.step_pulse;
    end

    initial begin : stimulus
        int k;
        reset        = 1'b1;
        bus.sw_raw   = 2'b00;
        bus.step_btn = 1'b0;
        bus.auto_en  = 1'b0;
        tick(3);
        check("reset_sw_out", int'(bus.sw_out), 0);
        check("reset_step_pulse", int'(bus.step_pulse), 0);
        check("reset_step_count", int'(bus.step_count), 0);
        check("reset_btn_state", int'(bus.btn_state), int'(BTN_IDLE));
        reset = 1'b0;
        tick(2);

        // Clean switch change: 2 sync + DEB count + 1 update edges.
        k = cyc;
        bus.sw_raw = 2'b10;
        tick(6);
        check("sw_before_accept", int'(bus.sw_out), 0);
        tick(1);
        check("sw_accepted", int'(bus.sw_out), 2);
        bus.sw_raw = 2'b00;
        tick(10);
        check("sw_back_to_00", int'(bus.sw_out), 0);

        bus.sw_raw = 2'b01;
        tick(2);
        bus.sw_raw = 2'b00;
        tick(12);
        check("sw_glitch2_rejected", int'(bus.sw_out), 0);
        bus.sw_raw = 2'b01;
        tick(3);
        bus.sw_raw = 2'b00;
        tick(12);
        check("sw_glitch3_rejected", int'(bus.sw_out), 0);

        // Bouncing press then long hold: one pulse.
        bus.step_btn = 1'b1;
        tick(1);
        bus.step_btn = 1'b0;
        tick(1);
        bus.step_btn = 1'b1;
        k = cyc;
        expect_pulse(k + 3 + DEB);
        tick(20);
        check("btn_held", int'(bus.btn_state), int'(BTN_HELD));
        check("count_after_press", int'(bus.step_count), 1);
        check("pending_after_press", exp_q.size(), 0);
        bus.step_btn = 1'b0;
        tick(10);
        check("btn_released", int'(bus.btn_state), int'(BTN_IDLE));

        // Auto stepping for 40 cycles.
        k = cyc;
        bus.auto_en = 1'b1;
        for (int i = 1; i <= 5; i++) expect_pulse(k + AP * i);
        tick(40);
        bus.auto_en = 1'b0;
        tick(20);
        check("count_after_auto", int'(bus.step_count), 6);
        check("pending_after_auto", exp_q.size(), 0);

        // Manual coincides with auto at k+8; manual at k+25 follows auto at k+24.
        k = cyc;
        bus.auto_en = 1'b1;
        expect_pulse(k + 8);
        expect_pulse(k + 16);
        expect_pulse(k + 24);
        tick(1);
        bus.step_btn = 1'b1;
        tick(7);
        bus.step_btn = 1'b0;
        tick(10);
        bus.step_btn = 1'b1;
        tick(7);
        bus.step_btn = 1'b0;
        tick(1);
        bus.auto_en = 1'b0;
        tick(20);
        check("count_after_overlap", int'(bus.step_count), 9);
        check("btn_idle_after_overlap", int'(bus.btn_state), int'(BTN_IDLE));
        check("pending_after_overlap", exp_q.size(), 0);

        // Wrap step_count through 255.
        k = cyc;
        bus.auto_en = 1'b1;
        for (int i = 1; i <= 247; i++) expect_pulse(k + AP * i);
        tick(AP * 246);
        check("count_at_255", int'(bus.step_count), 255);
        tick(AP);
        check("count_wrapped", int'(bus.step_count), 0);
        bus.auto_en = 1'b0;
        tick(10);
        check("pending_after_wrap", exp_q.size(), 0);

        // Reset during PRESS_WAIT; button stays held and is re-debounced.
        bus.step_btn = 1'b1;
        tick(3);
        check("btn_press_wait", int'(bus.btn_state), int'(BTN_PRESS_WAIT));
        reset = 1'b1;
        tick(1);
        check("reset_mid_press_state", int'(bus.btn_state), int'(BTN_IDLE));
        check("reset_mid_press_pulse", int'(bus.step_pulse), 0);
        check("reset_mid_press_count", int'(bus.step_count), 0);
        exp_count = 8'd0;
        tick(1);
        reset = 1'b0;
        k = cyc;
        expect_pulse(k + 3 + DEB);
        tick(15);
        check("btn_held_after_reset", int'(bus.btn_state), int'(BTN_HELD));
        check("count_after_reset_press", int'(bus.step_count), 1);
        bus.step_btn = 1'b0;
        tick(10);
        check("btn_idle_final", int'(bus.btn_state), int'(BTN_IDLE));
        check("pending_final", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
